// File: rtl/waveform_uart_streamer_if.sv
// Command, sample-RAM read port and serial-line signals of waveform_uart_streamer.
interface waveform_uart_streamer_if #(
  parameter int unsigned SAMPLE_W = 14,
  parameter int unsigned NCH      = 2
);
  logic                start;
  logic                abort;
  logic [NCH-1:0]      ch_mask;
  logic [15:0]         wave_number;
  logic                rd_en;
  logic [1:0]          rd_ch;
  logic [15:0]         rd_addr;
  logic [SAMPLE_W-1:0] rd_data;
  logic                uart_tx;
  logic                busy;
  logic                done;

  modport master (output start, abort, ch_mask, wave_number, rd_data,
                  input  rd_en, rd_ch, rd_addr, uart_tx, busy, done);
  modport slave  (input  start, abort, ch_mask, wave_number, rd_data,
                  output rd_en, rd_ch, rd_addr, uart_tx, busy, done);
endinterface

// File: rtl/waveform_uart_streamer.sv
// Streams masked sample channels from a synchronous RAM as 3-byte UART records,
// then a trailer with the wave number and an XOR checksum.
module waveform_uart_streamer #(
  parameter int unsigned SAMPLE_W     = 14,
  parameter int unsigned DEPTH        = 1000,
  parameter int unsigned NCH          = 2,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 3
) (
  input logic                      clk,
  input logic                      rst,
  waveform_uart_streamer_if.slave  bus
);
  localparam int unsigned FRAME_BITS = 9 + STOP_BITS;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
  localparam int unsigned CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CH_IW      = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, CAPTURE, SEND, TRAILER_LOAD, TRAILER_GAP, TRAILER_SEND
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         ch_q, ch_d;
  logic [15:0]        idx_q, idx_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic [15:0]        wave_q, wave_d;
  logic [7:0]         csum_q, csum_d;
  logic [23:0]        buf_q, buf_d;
  logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [1:0]         frame_q, frame_d;
  logic               abort_q, abort_d;
  logic               rd_en_q, rd_en_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SAMPLE_W-1:0] sample;
  logic [13:0]         sample_ext;
  logic [7:0]          rec_b0, rec_b1, rec_b2;
  logic [7:0]          cur_byte;
  logic [1:0]          first_ch, next_ch;
  logic                has_first, has_next;

  assign sample     = bus.rd_data;
  assign sample_ext = 14'(sample);
  assign rec_b0     = {ch_q, sample_ext[13:8]};
  assign rec_b1     = sample_ext[7:0];
  assign rec_b2     = 8'(idx_q + 16'd1);

  // Lowest enabled channel for a new start, and next enabled channel above the current one.
  always_comb begin
    first_ch  = 2'd0;
    has_first = 1'b0;
    next_ch   = 2'd0;
    has_next  = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (bus.ch_mask[CH_IW'(i)] && !has_first) begin
        first_ch  = 2'(i);
        has_first = 1'b1;
      end
      if (mask_q[CH_IW'(i)] && !has_next && (2'(i) > ch_q)) begin
        next_ch  = 2'(i);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    wave_d    = wave_q;
    csum_d    = csum_q;
    buf_d     = buf_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    tx_d      = 1'b1;
    cur_byte  = 8'h00;
    // Abort is only armed by an accepted start when idle.
    abort_d   = (state_q == IDLE) ? (bus.start & bus.abort) : (abort_q | bus.abort);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mask_d    = bus.ch_mask;
          wave_d    = bus.wave_number;
          csum_d    = bus.wave_number[15:8] ^ bus.wave_number[7:0];
          ch_d      = first_ch;
          idx_d     = 16'd0;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          frame_d   = 2'd0;
          state_d   = has_first ? FETCH : TRAILER_LOAD;
        end
      end
      FETCH:   state_d = CAPTURE;
      CAPTURE: begin
        buf_d   = {rec_b2, rec_b1, rec_b0};
        csum_d  = csum_q ^ rec_b0 ^ rec_b1 ^ rec_b2;
        state_d = SEND;
      end
      SEND, TRAILER_SEND: begin
        if (clk_cnt_q != CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end else begin
          clk_cnt_d = '0;
          if (bit_cnt_q != BIT_W'(FRAME_BITS - 1)) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end else begin
            bit_cnt_d = '0;
            if (abort_d) begin
              frame_d = 2'd0;
              state_d = IDLE;
            end else if (frame_q != 2'd2) begin
              frame_d = frame_q + 2'd1;
              buf_d   = {8'h00, buf_q[23:8]};
            end else begin
              frame_d = 2'd0;
              if (state_q == TRAILER_SEND) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else if (idx_q != 16'(DEPTH - 1)) begin
                idx_d   = idx_q + 16'd1;
                state_d = FETCH;
              end else begin
                idx_d = 16'd0;
                if (has_next) begin
                  ch_d    = next_ch;
                  state_d = FETCH;
                end else begin
                  state_d = TRAILER_LOAD;
                end
              end
            end
          end
        end
      end
      TRAILER_LOAD: begin
        buf_d   = {csum_q, wave_q[7:0], wave_q[15:8]};
        state_d = TRAILER_GAP;
      end
      TRAILER_GAP: state_d = TRAILER_SEND;
      default:     state_d = IDLE;
    endcase

    // Registered outputs follow the upcoming cycle's state and bit position.
    rd_en_d  = (state_d == FETCH);
    busy_d   = (state_d != IDLE);
    cur_byte = buf_d[7:0];
    if (state_d == SEND || state_d == TRAILER_SEND) begin
      if (bit_cnt_d == '0) begin
        tx_d = 1'b0;
      end else if (bit_cnt_d <= BIT_W'(8)) begin
        tx_d = cur_byte[3'(bit_cnt_d - BIT_W'(1))];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ch_q      <= 2'd0;
      idx_q     <= 16'd0;
      mask_q    <= '0;
      wave_q    <= 16'd0;
      csum_q    <= 8'd0;
      buf_q     <= 24'd0;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      frame_q   <= 2'd0;
      abort_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      wave_q    <= wave_d;
      csum_q    <= csum_d;
      buf_q     <= buf_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      abort_q   <= abort_d;
      rd_en_q   <= rd_en_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_ch   = ch_q;
  assign bus.rd_addr = idx_q;
  assign bus.uart_tx = tx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_waveform_uart_streamer.sv
// Directed bench: two streamer configurations, UART receivers, RAM models and a byte-stream model.
module tb_waveform_uart_streamer;
  localparam int unsigned SW = 14;

  typedef struct {
    bit         active;
    int         off;
    logic [7:0] sh;
    int         err;
  } rx_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  rx_t        rxa = '{default: 0};
  rx_t        rxb = '{default: 0};
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         ta[$];
  int         tbq[$];
  int         done_cnt_a = 0;
  int         done_cyc_a = 0;
  int         done_cnt_b = 0;
  int         done_cyc_b = 0;

  waveform_uart_streamer_if #(.SAMPLE_W(SW), .NCH(2)) bus_a ();
  waveform_uart_streamer_if #(.SAMPLE_W(SW), .NCH(2)) bus_b ();

  waveform_uart_streamer #(.SAMPLE_W(SW), .DEPTH(4), .NCH(2), .CLKS_PER_BIT(1), .STOP_BITS(3))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  waveform_uart_streamer #(.SAMPLE_W(SW), .DEPTH(300), .NCH(2), .CLKS_PER_BIT(4), .STOP_BITS(1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [SW-1:0] ram_val(input bit special, input logic [1:0] ch, input logic [15:0] a);
    if (special && ch == 2'd0 && a == 16'd0) return 14'h3ABC;
    if (special && ch == 2'd1 && a == 16'd2) return 14'h1234;
    return {ch, 4'h0, a[7:0]};
  endfunction

  always @(posedge clk) if (bus_a.rd_en) bus_a.rd_data <= ram_val(1'b1, bus_a.rd_ch, bus_a.rd_addr);
  always @(posedge clk) if (bus_b.rd_en) bus_b.rd_data <= ram_val(1'b0, bus_b.rd_ch, bus_b.rd_addr);

  task automatic rx_step(inout rx_t s, input logic tx, input int cpb, input int sb,
                         output bit got, output logic [7:0] b);
    int bi;
    got = 1'b0;
    b   = 8'h00;
    if (!s.active) begin
      if (tx == 1'b0) begin
        s.active = 1'b1;
        s.off    = 0;
      end
    end else begin
      s.off++;
    end
    if (s.active) begin
      bi = s.off / cpb;
      if (bi == 0 && tx !== 1'b0) s.err++;
      if (bi >= 1 && bi <= 8 && (s.off % cpb) == 0) s.sh[3'(bi - 1)] = tx;
      if (bi >= 9 && tx !== 1'b1) s.err++;
      if (s.off == cpb * (9 + sb) - 1) begin
        got      = 1'b1;
        b        = s.sh;
        s.active = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin : rx_a
    bit         g;
    logic [7:0] b;
    if (rst) begin
      rxa.active = 1'b0;
    end else begin
      rx_step(rxa, bus_a.uart_tx, 1, 3, g, b);
      if (g) begin
        qa.push_back(b);
        ta.push_back(cyc);
      end
    end
    if (bus_a.done) begin
      done_cnt_a++;
      done_cyc_a = cyc;
    end
  end

  always @(negedge clk) begin : rx_b
    bit         g;
    logic [7:0] b;
    if (rst) begin
      rxb.active = 1'b0;
    end else begin
      rx_step(rxb, bus_b.uart_tx, 4, 1, g, b);
      if (g) begin
        qb.push_back(b);
        tbq.push_back(cyc);
      end
    end
    if (bus_b.done) begin
      done_cnt_b++;
      done_cyc_b = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_start_a(input logic [1:0] m, input logic [15:0] w, output int t);
    @(negedge clk);
    bus_a.ch_mask     = m;
    bus_a.wave_number = w;
    bus_a.start       = 1'b1;
    t = cyc;
    @(negedge clk);
    bus_a.start = 1'b0;
  endtask

  task automatic wait_done_a(input int d0, input int limit);
    int lim;
    lim = cyc + limit;
    while (done_cnt_a == d0 && cyc < lim) @(negedge clk);
    check("a_done_seen", 32'(done_cnt_a - d0), 32'd1);
  endtask

  task automatic build_exp(input bit special, input int depth, input logic [1:0] m,
                           input logic [15:0] w, output logic [7:0] e[$]);
    logic [7:0]    cs;
    logic [SW-1:0] s;
    logic [7:0]    r[3];
    e.delete();
    cs = w[15:8] ^ w[7:0];
    for (int c = 0; c < 2; c++) begin
      if (m[c]) begin
        for (int i = 0; i < depth; i++) begin
          s    = ram_val(special, 2'(c), 16'(i));
          r[0] = {2'(c), s[13:8]};
          r[1] = s[7:0];
          r[2] = 8'(i + 1);
          for (int k = 0; k < 3; k++) begin
            e.push_back(r[k]);
            cs ^= r[k];
          end
        end
      end
    end
    e.push_back(w[15:8]);
    e.push_back(w[7:0]);
    e.push_back(cs);
  endtask

  task automatic cmp_stream(input string tag, input logic [7:0] e[$]);
    check({tag, "_len"}, 32'(qa.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < qa.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(qa[i]), 32'(e[i]));
  endtask

  initial begin
    int         t;
    int         d0;
    logic [7:0] e[$];

    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.ch_mask = 2'b00; bus_a.wave_number = 16'h0;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.ch_mask = 2'b00; bus_b.wave_number = 16'h0;

    @(negedge clk);
    check("rst_tx",      32'(bus_a.uart_tx), 32'd1);
    check("rst_busy",    32'(bus_a.busy),    32'd0);
    check("rst_done",    32'(bus_a.done),    32'd0);
    check("rst_rd_en",   32'(bus_a.rd_en),   32'd0);
    check("rst_rd_ch",   32'(bus_a.rd_ch),   32'd0);
    check("rst_rd_addr", 32'(bus_a.rd_addr), 32'd0);
    check("rst_b_tx",    32'(bus_b.uart_tx), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Both channels, plus a start pulse while busy that must be ignored.
    qa.delete(); ta.delete(); d0 = done_cnt_a;
    pulse_start_a(2'b11, 16'hA55A, t);
    at_cyc(t + 1);
    check("a1_rd_en_t1", 32'(bus_a.rd_en), 32'd1);
    check("a1_busy_t1",  32'(bus_a.busy),  32'd1);
    at_cyc(t + 2);
    check("a1_tx_t2",    32'(bus_a.uart_tx), 32'd1);
    check("a1_rd_en_t2", 32'(bus_a.rd_en),   32'd0);
    at_cyc(t + 3);
    check("a1_tx_t3",    32'(bus_a.uart_tx), 32'd0);
    at_cyc(t + 50);
    bus_a.ch_mask = 2'b01; bus_a.wave_number = 16'h0000; bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    wait_done_a(d0, 1000);
    repeat (2) @(negedge clk);
    check("a1_ch0r0_b0", 32'(qa[0]),  32'h3A);
    check("a1_ch0r0_b1", 32'(qa[1]),  32'hBC);
    check("a1_ch0r0_b2", 32'(qa[2]),  32'h01);
    check("a1_ch1r2_b0", 32'(qa[18]), 32'h52);
    check("a1_ch1r2_b1", 32'(qa[19]), 32'h34);
    check("a1_ch1r2_b2", 32'(qa[20]), 32'h03);
    check("a1_trl_hi",   32'(qa[24]), 32'hA5);
    check("a1_trl_lo",   32'(qa[25]), 32'h5A);
    check("a1_csum",     32'(qa[26]), 32'h4D);
    check("a1_first_end", 32'(ta[0]),  32'(t + 14));
    check("a1_last_end",  32'(ta[26]), 32'(t + 342));
    check("a1_done_cyc",  32'(done_cyc_a), 32'(t + 343));
    check("a1_busy_end",  32'(bus_a.busy), 32'd0);
    build_exp(1'b1, 4, 2'b11, 16'hA55A, e);
    cmp_stream("a1", e);

    // Channel 1 only.
    qa.delete(); ta.delete(); d0 = done_cnt_a;
    pulse_start_a(2'b10, 16'hBEEF, t);
    wait_done_a(d0, 1000);
    repeat (2) @(negedge clk);
    check("a2_b0_ch1",  32'(qa[0]),  32'h50);
    check("a2_r2_b0",   32'(qa[6]),  32'h52);
    check("a2_trl_hi",  32'(qa[12]), 32'hBE);
    check("a2_trl_lo",  32'(qa[13]), 32'hEF);
    check("a2_csum",    32'(qa[14]), 32'h61);
    check("a2_done_cyc", 32'(done_cyc_a), 32'(t + 191));
    build_exp(1'b1, 4, 2'b10, 16'hBEEF, e);
    cmp_stream("a2", e);

    // Empty mask: trailer only.
    qa.delete(); ta.delete(); d0 = done_cnt_a;
    pulse_start_a(2'b00, 16'hBEEF, t);
    wait_done_a(d0, 200);
    repeat (2) @(negedge clk);
    check("a3_len",      32'(qa.size()), 32'd3);
    check("a3_csum",     32'(qa[2]), 32'h51);
    check("a3_first_end", 32'(ta[0]), 32'(t + 14));
    check("a3_done_cyc", 32'(done_cyc_a), 32'(t + 39));

    // Abort during the byte1 start bit.
    qa.delete(); ta.delete(); d0 = done_cnt_a;
    pulse_start_a(2'b11, 16'h1234, t);
    at_cyc(t + 15);
    check("a4_tx_b1_start", 32'(bus_a.uart_tx), 32'd0);
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.abort = 1'b0;
    at_cyc(t + 26);
    check("a4_busy_last_stop", 32'(bus_a.busy), 32'd1);
    at_cyc(t + 27);
    check("a4_busy_after", 32'(bus_a.busy), 32'd0);
    repeat (60) @(negedge clk);
    check("a4_len",     32'(qa.size()), 32'd2);
    check("a4_b1",      32'(qa[1]), 32'hBC);
    check("a4_b1_end",  32'(ta[1]), 32'(t + 26));
    check("a4_no_done", 32'(done_cnt_a - d0), 32'd0);
    check("a4_tx_idle", 32'(bus_a.uart_tx), 32'd1);

    // Reset while the line is low mid-frame.
    qa.delete(); ta.delete();
    pulse_start_a(2'b11, 16'h0000, t);
    at_cyc(t + 4);
    check("a5_tx_low", 32'(bus_a.uart_tx), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("a5_rst_tx",    32'(bus_a.uart_tx), 32'd1);
    check("a5_rst_busy",  32'(bus_a.busy),    32'd0);
    check("a5_rst_rd_en", 32'(bus_a.rd_en),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("a5_no_bytes", 32'(qa.size()), 32'd0);
    check("a5_tx_idle",  32'(bus_a.uart_tx), 32'd1);
    check("a5_idle_busy", 32'(bus_a.busy), 32'd0);
    check("a_rx_frame_err", 32'(rxa.err), 32'd0);

    // Slow line, single stop bit, 300 samples on channel 0.
    qb.delete(); tbq.delete(); d0 = done_cnt_b;
    @(negedge clk);
    bus_b.ch_mask = 2'b01; bus_b.wave_number = 16'h0001; bus_b.start = 1'b1;
    t = cyc;
    @(negedge clk);
    bus_b.start = 1'b0;
    at_cyc(t + 2);
    check("b_tx_t2", 32'(bus_b.uart_tx), 32'd1);
    at_cyc(t + 3);
    check("b_tx_t3", 32'(bus_b.uart_tx), 32'd0);
    at_cyc(t + 6);
    check("b_tx_t6", 32'(bus_b.uart_tx), 32'd0);
    begin
      int lim;
      lim = cyc + 40000;
      while (done_cnt_b == d0 && cyc < lim) @(negedge clk);
    end
    check("b_done_seen", 32'(done_cnt_b - d0), 32'd1);
    repeat (2) @(negedge clk);
    build_exp(1'b0, 300, 2'b01, 16'h0001, e);
    check("b_len",        32'(qb.size()), 32'd903);
    check("b_frame0_end", 32'(tbq[0]), 32'(t + 42));
    check("b_frame1_end", 32'(tbq[1]), 32'(t + 82));
    check("b_rec1_end",   32'(tbq[3]), 32'(t + 164));
    check("b_idx255_b1",  32'(qb[766]), 32'hFF);
    check("b_idx255_b2",  32'(qb[767]), 32'h00);
    check("b_idx299_b1",  32'(qb[898]), 32'h2B);
    check("b_idx299_b2",  32'(qb[899]), 32'h2C);
    check("b_trl_hi",     32'(qb[900]), 32'h00);
    check("b_trl_lo",     32'(qb[901]), 32'h01);
    check("b_csum",       32'(qb[902]), 32'(e[902]));
    check("b_done_cyc",   32'(done_cyc_b), 32'(t + 36723));
    check("b_rx_frame_err", 32'(rxb.err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
